operand_compare_stage: RTL and testbench

- Upstream sequencing stage for the 32-bit `equals` comparator in the Lab2 ALU datapath.
- Accepts two operands serially over a single shared input bus with a valid/ready handshake, and holds them stable on `x_out`/`y_out` while they drive `equals`.
- Captures the comparator output `eq_in` into a registered result with its own valid/ready handshake.
- Keeps saturating counters of comparisons performed and equal hits, for ALU status and debug.

---
 rtl/operand_compare_stage_pkg.sv | 14 +
 rtl/operand_compare_stage_sat_counter.sv | 35 +++
 rtl/operand_compare_stage.sv | 107 ++++++++++
 tb/tb_operand_compare_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/operand_compare_stage_pkg.sv
// Shared definitions for the operand sequencing stage in front of the `equals` comparator.
package operand_compare_stage_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 32;
  localparam int unsigned DEFAULT_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_WAIT_X = 2'd0,
    ST_WAIT_Y = 2'd1,
    ST_CMP    = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/operand_compare_stage_sat_counter.sv
// Unsigned up-counter that sticks at all-ones; clear wins over a same-cycle increment.
module sat_counter
  import operand_compare_stage_pkg::*;
#(
  parameter int unsigned W = DEFAULT_CNT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/operand_compare_stage.sv
// Collects X then Y over one bus, holds them on the external `equals`, and registers its answer.
module operand_compare_stage
  import operand_compare_stage_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     x_out,
  output logic [WIDTH-1:0]     y_out,
  output logic                 op_valid,
  input  logic                 eq_in,
  output logic                 result,
  output logic                 result_valid,
  input  logic                 result_ready,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] cmp_count,
  output logic [CNT_WIDTH-1:0] eq_count
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             result_q, result_d;
  logic             cmp_inc, eq_inc;

  // Handshake outputs decode from state alone, so no input reaches an output combinationally.
  always_comb begin
    in_ready     = (state_q == ST_WAIT_X) || (state_q == ST_WAIT_Y);
    op_valid     = (state_q == ST_CMP);
    result_valid = (state_q == ST_RESULT);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    cmp_inc  = 1'b0;
    eq_inc   = 1'b0;
    case (state_q)
      ST_WAIT_X: begin
        if (in_valid) begin
          x_d     = in_data;
          state_d = ST_WAIT_Y;
        end
      end
      ST_WAIT_Y: begin
        if (in_valid) begin
          y_d     = in_data;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        result_d = eq_in;
        cmp_inc  = 1'b1;
        eq_inc   = eq_in;
        state_d  = ST_RESULT;
      end
      ST_RESULT: begin
        if (result_ready) begin
          state_d = ST_WAIT_X;
        end
      end
      default: state_d = ST_WAIT_X;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_WAIT_X;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
    end
  end

  assign x_out  = x_q;
  assign y_out  = y_q;
  assign result = result_q;

  sat_counter #(.W(CNT_WIDTH)) u_cmp_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cmp_inc),
    .count (cmp_count)
  );

  sat_counter #(.W(CNT_WIDTH)) u_eq_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (eq_inc),
    .count (eq_count)
  );

endmodule

// File: tb/tb_operand_compare_stage.sv
// Scoreboard bench: the driver predicts each comparison outcome, a monitor checks what the stage presents.
module tb_operand_compare_stage;

  localparam int unsigned SAT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_out, y_out;
  logic        op_valid;
  logic        eq_in;
  logic        result;
  logic        result_valid;
  logic        result_ready;
  logic        cnt_clr;
  logic [7:0]  cmp_count, eq_count;

  always #5 clk = ~clk;

  operand_compare_stage #(.WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x_out        (x_out),
    .y_out        (y_out),
    .op_valid     (op_valid),
    .eq_in        (eq_in),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .cnt_clr      (cnt_clr),
    .cmp_count    (cmp_count),
    .eq_count     (eq_count)
  );

  // Stand-in for the external `equals` block.
  assign eq_in = (x_out == y_out);

  typedef struct {
    logic        res;
    logic [31:0] x;
    logic [31:0] y;
    int unsigned cmp;
    int unsigned eq;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned cyc     = 0;
  int unsigned cmp_m   = 0;
  int unsigned eq_m    = 0;
  logic        hold    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial begin
    result_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      result_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : monitor
    logic prev_op;
    logic prev_rv;
    prev_op = 1'b0;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_op = 1'b0;
        prev_rv = 1'b0;
      end else begin
        if (op_valid) begin
          chk("op_valid_single_cycle", {31'd0, prev_op}, 32'd0);
          if (sb.size() == 0) chk("op_valid_without_pair", sb.size(), 32'd1);
          else chk("op_valid_latency", cyc - sb[0].acc, 32'd1);
        end
        if (result_valid) begin
          chk("in_ready_low_in_result", {31'd0, in_ready}, 32'd0);
          if (sb.size() == 0) begin
            chk("result_without_pair", sb.size(), 32'd1);
          end else begin
            if (!prev_rv) chk("result_latency", cyc - sb[0].acc, 32'd2);
            chk("result", {31'd0, result}, {31'd0, sb[0].res});
            chk("x_out_hold", x_out, sb[0].x);
            chk("y_out_hold", y_out, sb[0].y);
            if (result_ready) begin
              chk("cmp_count", {24'd0, cmp_count}, sb[0].cmp);
              chk("eq_count", {24'd0, eq_count}, sb[0].eq);
              void'(sb.pop_front());
            end
          end
        end
        prev_op = op_valid;
        prev_rv = result_valid;
      end
    end
  end

  // Present a beat from a negedge and wait (bounded) until it will be taken at the next edge.
  task automatic offer(input logic [31:0] d);
    int unsigned n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send_pair(input logic [31:0] x, input logic [31:0] y, input bit clr);
    exp_t e;
    offer(x);
    @(negedge clk);
    in_valid = 1'b0;
    offer(y);
    if (clr) begin
      cmp_m = 0;
      eq_m  = 0;
    end else begin
      cmp_m = (cmp_m < SAT) ? cmp_m + 1 : SAT;
      if (x == y) eq_m = (eq_m < SAT) ? eq_m + 1 : SAT;
    end
    e = '{res: (x == y), x: x, y: y, cmp: cmp_m, eq: eq_m, acc: cyc};
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom();
    if (clr) begin
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic check_idle_after_reset(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_x_out"}, x_out, 32'd0);
    chk({tag, "_y_out"}, y_out, 32'd0);
    chk({tag, "_result"}, {29'd0, result, result_valid, op_valid}, 32'd0);
    chk({tag, "_counts"}, {16'd0, cmp_count, eq_count}, 32'd0);
  endtask

  initial begin
    logic [31:0] rx, ry;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    cnt_clr  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_after_reset("reset");

    send_pair(32'h0000_0000, 32'h0000_0000, 1'b0);
    send_pair(32'h0000_0001, 32'h0000_0000, 1'b0);
    send_pair(32'hffff_ffff, 32'hff7f_ffff, 1'b0);
    drain();

    hold = 1'b1;
    @(negedge clk);
    send_pair($urandom(), $urandom(), 1'b0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      @(negedge clk);
      chk("bp_result_valid", {31'd0, result_valid}, 32'd1);
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    send_pair(32'hdead_beef, 32'hdead_beef, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rx = $urandom();
      case ($urandom_range(0, 2))
        0:       ry = rx;
        1:       ry = $urandom();
        default: ry = rx ^ (32'h1 << $urandom_range(0, 31));
      endcase
      send_pair(rx, ry, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    offer(32'h1234_5678);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    cmp_m = 0;
    eq_m  = 0;
    check_idle_after_reset("mid_reset");

    for (int i = 0; i < 300; i++) send_pair(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
    drain();
    chk("sat_cmp_count", {24'd0, cmp_count}, SAT);
    chk("sat_eq_count", {24'd0, eq_count}, SAT);
    send_pair(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);
    send_pair(32'h0000_0002, 32'h0000_0003, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
